// File: rtl/modulo_equiv_checker.sv
// Streaming checker: expands two multi-symbol operands and reduces each mod MODULUS bit-serially.
// Compares the residues and keeps a saturating mismatch count plus a sticky first-mismatch capture.
module modulo_equiv_checker #(
  parameter int LOGRADIX         = 33,
  parameter int A_NUMSYMBOLS     = 65,
  parameter int A_SYMBOLBITWIDTH = 35,
  parameter int A_SIGNED         = 1,
  parameter int B_NUMSYMBOLS     = 32,
  parameter int B_SYMBOLBITWIDTH = 41,
  parameter int B_SIGNED         = 0,
  parameter int MODBITS          = 1024,
  // Default odd modulus; builds override it with the project modulus.
  parameter logic [MODBITS-1:0] MODULUS = {1'b1, {(MODBITS-2){1'b0}}, 1'b1},
  parameter int COUNTWIDTH       = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [A_NUMSYMBOLS*A_SYMBOLBITWIDTH-1:0] a_in,
  input  logic [B_NUMSYMBOLS*B_SYMBOLBITWIDTH-1:0] b_in,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     clear_counts,
  output logic                                     result_valid,
  output logic                                     result_match,
  output logic [MODBITS-1:0]                       residue_a,
  output logic [MODBITS-1:0]                       residue_b,
  output logic [COUNTWIDTH-1:0]                    err_count,
  output logic                                     first_err_valid,
  output logic [MODBITS-1:0]                       first_err_a,
  output logic [MODBITS-1:0]                       first_err_b
);

  localparam int WA   = (A_NUMSYMBOLS - 1) * LOGRADIX + A_SYMBOLBITWIDTH + $clog2(A_NUMSYMBOLS) + 1;
  localparam int WB   = (B_NUMSYMBOLS - 1) * LOGRADIX + B_SYMBOLBITWIDTH + $clog2(B_NUMSYMBOLS) + 1;
  localparam int W    = (WA > WB) ? WA : WB;
  localparam int CNTW = $clog2(W + 1);
  localparam logic [MODBITS:0] MOD_EXT = {1'b0, MODULUS};

  typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_REDUCE, S_FIXUP, S_REPORT} state_t;

  state_t                                     r_state, w_state_nxt;
  logic [A_NUMSYMBOLS*A_SYMBOLBITWIDTH-1:0]   r_a_lat;
  logic [B_NUMSYMBOLS*B_SYMBOLBITWIDTH-1:0]   r_b_lat;
  logic [W-1:0]                               r_sh_a, r_sh_b;
  logic                                       r_neg_a, r_neg_b;
  logic [MODBITS:0]                           r_rem_a, r_rem_b;
  logic [CNTW-1:0]                            r_cnt;
  logic                                       r_in_ready, r_result_valid, r_match;
  logic [MODBITS-1:0]                         r_res_a, r_res_b, r_first_a, r_first_b;
  logic                                       r_first_vld;
  logic [COUNTWIDTH-1:0]                      r_err_count;

  logic [W-1:0]       w_sum_a, w_sum_b, w_ext_a, w_ext_b, w_mag_a, w_mag_b;
  logic               w_neg_a, w_neg_b;
  logic [MODBITS:0]   w_step_a, w_step_b, w_nrem_a, w_nrem_b;
  logic [MODBITS-1:0] w_fix_a, w_fix_b;
  logic               w_accept, w_report, w_mismatch;

  // Exact operand values: every symbol is extended to W bits before its weighted add.
  always_comb begin
    w_sum_a = '0;
    w_ext_a = '0;
    for (int i = 0; i < A_NUMSYMBOLS; i++) begin
      w_ext_a = {{(W-A_SYMBOLBITWIDTH){(A_SIGNED != 0) && r_a_lat[i*A_SYMBOLBITWIDTH + A_SYMBOLBITWIDTH-1]}},
                 r_a_lat[i*A_SYMBOLBITWIDTH +: A_SYMBOLBITWIDTH]};
      w_sum_a = w_sum_a + (w_ext_a << (i * LOGRADIX));
    end
  end

  always_comb begin
    w_sum_b = '0;
    w_ext_b = '0;
    for (int i = 0; i < B_NUMSYMBOLS; i++) begin
      w_ext_b = {{(W-B_SYMBOLBITWIDTH){(B_SIGNED != 0) && b_sign_bit(i)}},
                 r_b_lat[i*B_SYMBOLBITWIDTH +: B_SYMBOLBITWIDTH]};
      w_sum_b = w_sum_b + (w_ext_b << (i * LOGRADIX));
    end
  end

  function automatic logic b_sign_bit(input int idx);
    return r_b_lat[idx*B_SYMBOLBITWIDTH + B_SYMBOLBITWIDTH-1];
  endfunction

  assign w_neg_a = w_sum_a[W-1];
  assign w_neg_b = w_sum_b[W-1];
  assign w_mag_a = w_neg_a ? (~w_sum_a + 1'b1) : w_sum_a;
  assign w_mag_b = w_neg_b ? (~w_sum_b + 1'b1) : w_sum_b;

  // One restoring step per channel: r stays below MODULUS, so 2r+bit fits MODBITS+1 bits.
  assign w_step_a = {r_rem_a[MODBITS-1:0], r_sh_a[W-1]};
  assign w_step_b = {r_rem_b[MODBITS-1:0], r_sh_b[W-1]};
  assign w_nrem_a = (w_step_a >= MOD_EXT) ? (w_step_a - MOD_EXT) : w_step_a;
  assign w_nrem_b = (w_step_b >= MOD_EXT) ? (w_step_b - MOD_EXT) : w_step_b;

  // A negative operand's residue of the magnitude is negated back into [0, MODULUS).
  assign w_fix_a = (r_neg_a && (r_rem_a != '0)) ? (MODULUS - r_rem_a[MODBITS-1:0]) : r_rem_a[MODBITS-1:0];
  assign w_fix_b = (r_neg_b && (r_rem_b != '0)) ? (MODULUS - r_rem_b[MODBITS-1:0]) : r_rem_b[MODBITS-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (in_valid && r_in_ready) w_state_nxt = S_CONVERT;
      S_CONVERT: w_state_nxt = S_REDUCE;
      S_REDUCE:  if (r_cnt == '0) w_state_nxt = S_FIXUP;
      S_FIXUP:   w_state_nxt = S_REPORT;
      S_REPORT:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept   = (r_state == S_IDLE) && in_valid && r_in_ready;
    w_report   = (r_state == S_REPORT);
    w_mismatch = w_report && !r_match;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_lat <= a_in;
      r_b_lat <= b_in;
    end
    case (r_state)
      S_CONVERT: begin
        r_sh_a  <= w_mag_a;
        r_sh_b  <= w_mag_b;
        r_neg_a <= w_neg_a;
        r_neg_b <= w_neg_b;
        r_rem_a <= '0;
        r_rem_b <= '0;
        r_cnt   <= CNTW'(W - 1);
      end
      S_REDUCE: begin
        r_rem_a <= w_nrem_a;
        r_rem_b <= w_nrem_b;
        r_sh_a  <= r_sh_a << 1;
        r_sh_b  <= r_sh_b << 1;
        r_cnt   <= r_cnt - 1'b1;
      end
      default: ;
    endcase
  end

  // Reported fields; a clear coinciding with a mismatch is applied before the mismatch is logged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready     <= 1'b0;
      r_result_valid <= 1'b0;
      r_match        <= 1'b0;
      r_res_a        <= '0;
      r_res_b        <= '0;
      r_err_count    <= '0;
      r_first_vld    <= 1'b0;
      r_first_a      <= '0;
      r_first_b      <= '0;
    end else begin
      r_in_ready     <= (w_state_nxt == S_IDLE);
      r_result_valid <= (r_state == S_FIXUP);
      if (r_state == S_FIXUP) begin
        r_res_a <= w_fix_a;
        r_res_b <= w_fix_b;
        r_match <= (w_fix_a == w_fix_b);
      end
      if (clear_counts) begin
        r_err_count <= '0;
        r_first_vld <= 1'b0;
      end
      if (w_mismatch) begin
        if (clear_counts)             r_err_count <= COUNTWIDTH'(1);
        else if (r_err_count != '1)   r_err_count <= r_err_count + 1'b1;
        if (clear_counts || !r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_a   <= r_res_a;
          r_first_b   <= r_res_b;
        end
      end
    end
  end

  assign in_ready        = r_in_ready;
  assign result_valid    = r_result_valid;
  assign result_match    = r_match;
  assign residue_a       = r_res_a;
  assign residue_b       = r_res_b;
  assign err_count       = r_err_count;
  assign first_err_valid = r_first_vld;
  assign first_err_a     = r_first_a;
  assign first_err_b     = r_first_b;

endmodule

// File: tb/tb_modulo_equiv_checker.sv
// Scoreboard bench for modulo_equiv_checker with a small 4-bit modulus (13).
module tb_modulo_equiv_checker;
  localparam int LR = 4, AN = 3, AW = 6, BN = 2, BW = 6, MB = 4, CW = 2, LAT = 20;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, clear_counts;
  logic [AN*AW-1:0]     a_in;
  logic [BN*BW-1:0]     b_in;
  logic                 in_ready, result_valid, result_match, first_err_valid;
  logic [MB-1:0]        residue_a, residue_b, first_err_a, first_err_b;
  logic [CW-1:0]        err_count;

  typedef struct { int ra; int rb; int acc; } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_err = 0, cyc = 0;
  int m_cnt = 0, m_fv = 0, m_fa = 0, m_fb = 0;
  int acc_t[2];
  int acc_n, leak, rv_seen;
  bit chg;

  modulo_equiv_checker #(
    .LOGRADIX(LR), .A_NUMSYMBOLS(AN), .A_SYMBOLBITWIDTH(AW), .A_SIGNED(1),
    .B_NUMSYMBOLS(BN), .B_SYMBOLBITWIDTH(BW), .B_SIGNED(0),
    .MODBITS(MB), .MODULUS(4'd13), .COUNTWIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
    .clear_counts(clear_counts), .result_valid(result_valid), .result_match(result_match),
    .residue_a(residue_a), .residue_b(residue_b), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_a(first_err_a), .first_err_b(first_err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mod13(input int v);
    int r;
    r = v % 13;
    if (r < 0) r += 13;
    return r;
  endfunction

  function automatic int val_a(input logic [AN*AW-1:0] a);
    int s;
    logic signed [AW-1:0] t;
    s = 0;
    for (int i = 0; i < AN; i++) begin
      t = a[i*AW +: AW];
      s += int'(t) * (1 << (LR*i));
    end
    return s;
  endfunction

  function automatic int val_b(input logic [BN*BW-1:0] b);
    int s;
    logic [BW-1:0] u;
    s = 0;
    for (int i = 0; i < BN; i++) begin
      u = b[i*BW +: BW];
      s += int'(u) * (1 << (LR*i));
    end
    return s;
  endfunction

  task automatic push(input logic [AN*AW-1:0] a, input logic [BN*BW-1:0] b);
    exp_t e;
    e.ra  = mod13(val_a(a));
    e.rb  = mod13(val_b(b));
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic pop_check(input bit clr);
    exp_t e;
    bit mis;
    check("sb_depth", sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("latency", cyc - e.acc, LAT);
    check("residue_a", residue_a, e.ra);
    check("residue_b", residue_b, e.rb);
    mis = (e.ra != e.rb);
    check("match", result_match, !mis);
    if (clr) begin m_cnt = 0; m_fv = 0; end
    if (mis) begin
      if (m_cnt < 3) m_cnt++;
      if (m_fv == 0) begin m_fv = 1; m_fa = e.ra; m_fb = e.rb; end
    end
  endtask

  task automatic check_counts();
    check("err_count", err_count, m_cnt);
    check("first_err_valid", first_err_valid, m_fv);
    if (m_fv != 0) begin
      check("first_err_a", first_err_a, m_fa);
      check("first_err_b", first_err_b, m_fb);
    end
  endtask

  task automatic send(input logic [AN*AW-1:0] a, input logic [BN*BW-1:0] b);
    int k;
    k = 0;
    a_in = a; b_in = b; in_valid = 1'b1;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    check("accept_timeout", k < 50, 1);
    push(a, b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input bit clr);
    int k;
    k = 0;
    while (!result_valid && k < 40) begin @(negedge clk); k++; end
    check("result_timeout", k < 40, 1);
    if (k >= 40) return;
    clear_counts = clr;
    pop_check(clr);
    @(negedge clk);
    clear_counts = 1'b0;
    check("result_pulse", result_valid, 0);
    check("ready_after", in_ready, 1);
    check_counts();
  endtask

  task automatic run_op(input logic [AN*AW-1:0] a, input logic [BN*BW-1:0] b, input bit clr);
    send(a, b);
    wait_result(clr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; clear_counts = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("ready_in_reset", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    check("rv_reset", result_valid, 0);
    check("match_reset", result_match, 0);
    check("res_a_reset", residue_a, 0);
    check("res_b_reset", residue_b, 0);
    check_counts();

    // Basic matches, negative operands, the zero-residue negative case and a large A.
    run_op({6'd0, 6'd0, 6'd1},    {6'd0, 6'd1},  1'b0);
    run_op({6'd0, 6'd0, 6'h3F},   {6'd0, 6'd12}, 1'b0);
    run_op({6'd0, 6'd0, 6'h33},   {6'd0, 6'd0},  1'b0);
    run_op({6'd1, 6'd0, 6'd0},    {6'd0, 6'd9},  1'b0);
    run_op({6'd1, 6'd0, 6'd0},    {6'd0, 6'd8},  1'b0);
    run_op({6'd0, 6'd0, 6'd1},    {6'd0, 6'd2},  1'b0);
    // Saturation, then a clear coinciding with a mismatching report.
    for (int i = 0; i < 4; i++) run_op({6'd0, 6'd0, 6'(i + 1)}, {6'd0, 6'(i + 3)}, 1'b0);
    run_op({6'd0, 6'd0, 6'd5},    {6'd0, 6'd7},  1'b1);
    run_op({6'h20, 6'd0, 6'd0},   {6'h3F, 6'h3F}, 1'b0);

    // in_valid held high; operands change while each operation is in flight.
    acc_n = 0; leak = 0; chg = 1'b0;
    a_in = {6'd0, 6'd2, 6'd3}; b_in = {6'd2, 6'd3}; in_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (acc_n >= 2 && sb.size() == 0) break;
      if (in_ready && sb.size() > 0) leak++;
      if (result_valid) pop_check(1'b0);
      if (in_valid && in_ready) begin
        push(a_in, b_in);
        if (acc_n < 2) acc_t[acc_n] = cyc;
        acc_n++;
        chg = 1'b1;
      end else if (chg) begin
        chg = 1'b0;
        if (acc_n == 1) begin a_in = {6'h20, 6'd0, 6'd0}; b_in = {6'h3F, 6'h3F}; end
        else begin a_in = '1; b_in = '0; in_valid = 1'b0; end
      end
      @(negedge clk);
    end
    check("cont_accepts", acc_n, 2);
    check("cont_gap", acc_t[1] - acc_t[0], LAT + 1);
    check("cont_ready_low", leak, 0);
    @(negedge clk);
    check_counts();

    // Reset in the middle of the reduction aborts the operation.
    send({6'd0, 6'd0, 6'd1}, {6'd0, 6'd4});
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", in_ready, 0);
    check("abort_rv", result_valid, 0);
    check("abort_match", result_match, 0);
    check("abort_res_a", residue_a, 0);
    check("abort_res_b", residue_b, 0);
    check("abort_err", err_count, 0);
    check("abort_fev", first_err_valid, 0);
    check("abort_fea", first_err_a, 0);
    check("abort_feb", first_err_b, 0);
    rst = 1'b0;
    sb.delete();
    m_cnt = 0; m_fv = 0;
    rv_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    check("abort_no_result", rv_seen, 0);
    check("abort_ready_back", in_ready, 1);
    run_op({6'd0, 6'd2, 6'd3}, {6'd1, 6'd0}, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
